wb_wrr_sched: RTL and testbench

Weighted round-robin grant scheduler for one shared Wishbone slave port. It drives the master mux of a multi-master interconnect through `grant_o`, `select_o` and `active_o`. It adds three things over plain round-robin: per-master transfer quotas, burst-safe handover, and a bus watchdog that terminates stalled transfers. It sits between the masters' `cyc` lines and the mux, and observes the slave's termination signals.

---
 rtl/wb_wrr_sched_pkg.sv | 21 ++
 rtl/wb_wrr_sched_pick.sv | 32 +++
 rtl/wb_wrr_sched.sv | 145 ++++++++++++++
 tb/tb_wb_wrr_sched.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/wb_wrr_sched_pkg.sv
// Shared types and constants for the weighted round-robin Wishbone scheduler.
// Holds the CTI encodings and a clog2 helper that never returns 0.
package wb_wrr_sched_pkg;

  typedef enum logic {ST_IDLE, ST_OWN} wrr_state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Minimum of 1 so a single-master build still gets a usable select bus
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/wb_wrr_sched_pick.sv
// Combinational cyclic picker: first set request bit strictly after ptr,
// wrapping around, so ptr itself is considered last.
module wb_rr_pick
  import wb_wrr_sched_pkg::*;
#(
  parameter int num_masters = 2,
  parameter int sel_bits    = 1
) (
  input  logic [num_masters-1:0] req,
  input  logic [sel_bits-1:0]    ptr,
  output logic [num_masters-1:0] win,
  output logic [sel_bits-1:0]    idx,
  output logic                   any
);

  always_comb begin
    logic [sel_bits-1:0] i;
    win = '0;
    idx = '0;
    any = 1'b0;
    i   = '0;
    for (int k = 1; k <= num_masters; k++) begin
      i = sel_bits'((int'(ptr) + k) % num_masters);
      if (!any && req[i]) begin
        any    = 1'b1;
        win[i] = 1'b1;
        idx    = i;
      end
    end
  end

endmodule

// File: rtl/wb_wrr_sched.sv
// Weighted round-robin grant scheduler for a shared Wishbone slave port:
// per-master transfer quotas, burst-safe handover and a stall watchdog.
module wb_wrr_sched
  import wb_wrr_sched_pkg::*;
#(
  parameter int num_masters = 2,
  parameter int weight_w    = 4,
  parameter int timeout     = 256,
  localparam int master_sel_bits = clog2_min1(num_masters)
) (
  input  logic                            wb_clk_i,
  input  logic                            wb_rst_i,
  input  logic [num_masters-1:0]          wbm_cyc_i,
  input  logic [num_masters*weight_w-1:0] wbm_weight_i,
  input  logic                            wbs_stb_i,
  input  logic [2:0]                      wbs_cti_i,
  input  logic                            wbs_ack_i,
  input  logic                            wbs_err_i,
  input  logic                            wbs_rty_i,
  output logic [num_masters-1:0]          grant_o,
  output logic [master_sel_bits-1:0]      select_o,
  output logic                            active_o,
  output logic                            timeout_o
);

  localparam int WDT_W = clog2_min1(timeout > 1 ? timeout : 2);
  localparam logic [WDT_W-1:0] TMO_LAST = WDT_W'(timeout > 0 ? timeout - 1 : 0);

  wrr_state_e                 state_q, state_d;
  logic [num_masters-1:0]     grant_d;
  logic [master_sel_bits-1:0] select_d, last_q, last_d;
  logic [weight_w-1:0]        credit_q, credit_d;
  logic [WDT_W-1:0]           wdt_q, wdt_d;
  logic                       tmo_d;

  logic [num_masters-1:0][weight_w-1:0] wt;
  assign wt = wbm_weight_i;

  logic                       own, cur_cyc, term, end_xfer, quota_out, cti_closes, stall, handover;
  logic [num_masters-1:0]     pick_req, pick_win;
  logic [master_sel_bits-1:0] pick_ptr, pick_idx;
  logic                       pick_any;
  logic [weight_w-1:0]        wt_pick, wt_cur;

  assign own        = (state_q == ST_OWN);
  assign cur_cyc    = |(wbm_cyc_i & grant_o);
  assign term       = wbs_ack_i | wbs_err_i | wbs_rty_i;
  assign end_xfer   = own && wbs_stb_i && (term || timeout_o);
  assign quota_out  = end_xfer && (credit_q <= weight_w'(1));
  assign cti_closes = !(wbs_cti_i == CTI_CONST || wbs_cti_i == CTI_INC);
  assign stall      = own && wbs_stb_i && !term;
  assign handover   = own && cur_cyc && quota_out && cti_closes && pick_any;

  // One picker serves both the idle pick and the handover pick
  assign pick_req = own ? (wbm_cyc_i & ~grant_o) : wbm_cyc_i;
  assign pick_ptr = own ? select_o : last_q;

  wb_rr_pick #(.num_masters(num_masters), .sel_bits(master_sel_bits)) u_pick (
    .req (pick_req),
    .ptr (pick_ptr),
    .win (pick_win),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign wt_pick = wt[pick_idx];
  assign wt_cur  = wt[select_o];

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_o;
    select_d = select_o;
    credit_d = credit_q;
    last_d   = last_q;
    wdt_d    = wdt_q;
    tmo_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        wdt_d   = '0;
        grant_d = '0;
        if (pick_any) begin
          state_d  = ST_OWN;
          grant_d  = pick_win;
          select_d = pick_idx;
          credit_d = (wt_pick == '0) ? weight_w'(1) : wt_pick;
        end
      end
      ST_OWN: begin
        if (!cur_cyc) begin
          state_d = ST_IDLE;
          grant_d = '0;
          last_d  = select_o;
          wdt_d   = '0;
        end else begin
          if (end_xfer && credit_q != '0) credit_d = credit_q - 1'b1;
          if (quota_out && cti_closes) begin
            if (pick_any) begin
              grant_d  = pick_win;
              select_d = pick_idx;
              last_d   = pick_idx;
              credit_d = (wt_pick == '0) ? weight_w'(1) : wt_pick;
            end else begin
              credit_d = (wt_cur == '0) ? weight_w'(1) : wt_cur;
            end
          end
          // The new owner starts with a fresh watchdog window
          if (term || handover) begin
            wdt_d = '0;
          end else if (stall) begin
            if (timeout != 0 && wdt_q == TMO_LAST) begin
              wdt_d = '0;
              tmo_d = 1'b1;
            end else begin
              wdt_d = wdt_q + 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      grant_o   <= '0;
      select_o  <= '0;
      credit_q  <= '0;
      wdt_q     <= '0;
      last_q    <= master_sel_bits'(num_masters - 1);
      timeout_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_o   <= grant_d;
      select_o  <= select_d;
      credit_q  <= credit_d;
      wdt_q     <= wdt_d;
      last_q    <= last_d;
      timeout_o <= tmo_d;
    end
  end

  assign active_o = own;

endmodule

// File: tb/tb_wb_wrr_sched.sv
// Directed self-checking bench for wb_wrr_sched (2 masters, 4-bit weights, timeout 8).
module tb_wb_wrr_sched;

  logic       wb_clk_i = 1'b0;
  logic       wb_rst_i = 1'b1;
  logic [1:0] wbm_cyc_i = '0;
  logic [7:0] wbm_weight_i = '0;
  logic       wbs_stb_i = 1'b0;
  logic [2:0] wbs_cti_i = 3'b000;
  logic       wbs_ack_i = 1'b0, wbs_err_i = 1'b0, wbs_rty_i = 1'b0;
  logic [1:0] grant_o;
  logic [0:0] select_o;
  logic       active_o, timeout_o;

  int n_cmp = 0;
  int n_bad = 0;

  wb_wrr_sched #(.num_masters(2), .weight_w(4), .timeout(8)) dut (
    .wb_clk_i     (wb_clk_i),
    .wb_rst_i     (wb_rst_i),
    .wbm_cyc_i    (wbm_cyc_i),
    .wbm_weight_i (wbm_weight_i),
    .wbs_stb_i    (wbs_stb_i),
    .wbs_cti_i    (wbs_cti_i),
    .wbs_ack_i    (wbs_ack_i),
    .wbs_err_i    (wbs_err_i),
    .wbs_rty_i    (wbs_rty_i),
    .grant_o      (grant_o),
    .select_o     (select_o),
    .active_o     (active_o),
    .timeout_o    (timeout_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic idle_bus();
    wbm_cyc_i = '0; wbs_stb_i = 1'b0; wbs_ack_i = 1'b0; wbs_cti_i = 3'b000;
    tick();
    chk("release_active", 32'(active_o), 32'd0);
  endtask

  int         exp_seq[6] = '{0, 0, 1, 0, 0, 1};
  logic [2:0] burst_cti[4] = '{3'b010, 3'b010, 3'b010, 3'b111};

  initial begin
    // reset state
    tick(); tick();
    chk("rst_grant", 32'(grant_o), 32'd0);
    chk("rst_select", 32'(select_o), 32'd0);
    chk("rst_active", 32'(active_o), 32'd0);
    chk("rst_timeout", 32'(timeout_o), 32'd0);
    wb_rst_i = 1'b0;
    tick();

    // both raise cyc: master 0 first, one cycle later
    wbm_weight_i = {4'd1, 4'd2};
    wbm_cyc_i = 2'b11;
    tick();
    chk("first_grant", 32'(grant_o), 32'd1);
    chk("first_active", 32'(active_o), 32'd1);

    // weights 2/1, continuous classic singles: 0,0,1,0,0,1
    wbs_stb_i = 1'b1; wbs_ack_i = 1'b1; wbs_cti_i = 3'b000;
    for (int k = 0; k < 6; k++) begin
      chk("wrr_select", 32'(select_o), 32'(exp_seq[k]));
      chk("wrr_grant", 32'(grant_o), 32'(1 << exp_seq[k]));
      chk("wrr_active", 32'(active_o), 32'd1);
      tick();
    end
    idle_bus();

    // weight 1, INC burst of 4 by master 0 while master 1 waits
    wbm_weight_i = {4'd1, 4'd1};
    wbm_cyc_i = 2'b01;
    tick();
    chk("burst_grant0", 32'(grant_o), 32'd1);
    wbm_cyc_i = 2'b11; wbs_stb_i = 1'b1; wbs_ack_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wbs_cti_i = burst_cti[k];
      chk("burst_hold", 32'(select_o), 32'd0);
      tick();
    end
    chk("burst_handover_grant", 32'(grant_o), 32'd2);
    chk("burst_handover_active", 32'(active_o), 32'd1);
    idle_bus();

    // watchdog: master 0 (weight 2) stalls; pulses every 8 cycles, then quota handover
    wbm_weight_i = {4'd1, 4'd2};
    wbm_cyc_i = 2'b01;
    tick();
    chk("wdt_grant0", 32'(grant_o), 32'd1);
    wbm_cyc_i = 2'b11; wbs_stb_i = 1'b1; wbs_ack_i = 1'b0; wbs_cti_i = 3'b000;
    for (int t = 1; t <= 16; t++) begin
      tick();
      chk("wdt_pulse", 32'(timeout_o), (t == 8 || t == 16) ? 32'd1 : 32'd0);
    end
    tick();
    chk("wdt_handover_select", 32'(select_o), 32'd1);
    chk("wdt_handover_active", 32'(active_o), 32'd1);
    chk("wdt_handover_tmo", 32'(timeout_o), 32'd0);
    idle_bus();

    // cyc drop on the quota-exhausting ack beats handover
    wbm_weight_i = {4'd1, 4'd1};
    wbm_cyc_i = 2'b01;
    tick();
    chk("drop_grant0", 32'(grant_o), 32'd1);
    wbm_cyc_i = 2'b10; wbs_stb_i = 1'b1; wbs_ack_i = 1'b1; wbs_cti_i = 3'b000;
    tick();
    chk("drop_active", 32'(active_o), 32'd0);
    chk("drop_grant", 32'(grant_o), 32'd0);
    wbs_stb_i = 1'b0; wbs_ack_i = 1'b0;
    tick();
    chk("drop_regrant", 32'(grant_o), 32'd2);
    chk("drop_regrant_sel", 32'(select_o), 32'd1);
    idle_bus();

    // async reset mid-burst while master 1 owns the bus
    wbm_cyc_i = 2'b10;
    tick();
    chk("mid_grant1", 32'(grant_o), 32'd2);
    wbs_stb_i = 1'b1; wbs_ack_i = 1'b1; wbs_cti_i = 3'b010;
    tick();
    #2 wb_rst_i = 1'b1;
    #1;
    chk("async_rst_grant", 32'(grant_o), 32'd0);
    chk("async_rst_select", 32'(select_o), 32'd0);
    chk("async_rst_active", 32'(active_o), 32'd0);
    chk("async_rst_timeout", 32'(timeout_o), 32'd0);
    wbs_stb_i = 1'b0; wbs_ack_i = 1'b0; wbs_cti_i = 3'b000;
    wbm_cyc_i = 2'b11;
    tick();
    wb_rst_i = 1'b0;
    tick();
    chk("post_rst_grant", 32'(grant_o), 32'd1);
    chk("post_rst_select", 32'(select_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
